pc_unit: RTL and testbench

Parametrised program-counter unit for the IF stage of the MIPS pipeline. It is the successor to the fixed 8-bit PC register: it computes the sequential address internally and arbitrates branch, jump and return redirects. It adds a RUN/HALT/LOAD control state machine and an optional return-address stack (RAS). It drives the instruction-memory address and the IF/ID PC+step value.

---
 rtl/pc_unit.sv | 152 +++++++++++++++
 tb/tb_pc_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter unit for the IF stage: RUN/HALT/LOAD control, branch/jump/return redirects.
// Optional return-address stack is compiled in when PC_RAS_EN is defined.
module pc_unit #(
    parameter int PC_W      = 8,
    parameter int STEP      = 1,
    parameter int RESET_VEC = 0,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clk_en,
    input  logic            stall,
    input  logic            write_en,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            jmp_taken,
    input  logic [PC_W-1:0] jmp_target,
    input  logic            call,
    input  logic [PC_W-1:0] ret_addr,
    input  logic            ret,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus,
    output logic [1:0]      state,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_err
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HALT = 2'b01,
        ST_LOAD = 2'b10
    } state_t;

    localparam logic [PC_W-1:0] STEP_V  = PC_W'(STEP);
    localparam logic [PC_W-1:0] RESET_V = PC_W'(RESET_VEC);

    state_t          state_reg;
    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] pc_next;
    logic            advance;
    logic            take_seq;
    logic            do_pop;
    logic [PC_W-1:0] ras_top;

    assign pc_plus  = pc_reg + STEP_V;
    assign pc       = pc_reg;
    assign state    = state_reg;
    assign advance  = (state_reg == ST_RUN) & clk_en & ~stall & ~halt_req & ~write_en;
    // Cycles where neither a branch nor a jump redirects: ret (or plain sequencing) wins.
    assign take_seq = advance & ~br_taken & ~jmp_taken;

`ifdef PC_RAS_EN
    localparam int AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0] ras_mem [RAS_DEPTH];
    logic [AW-1:0]   sp_reg;
    logic [CW-1:0]   cnt_reg;
    logic            err_reg;
    logic            do_push;

    assign do_push   = advance & ~br_taken & jmp_taken & call;
    assign do_pop    = take_seq & ret & (cnt_reg != '0);
    assign ras_top   = ras_mem[sp_reg - AW'(1)];
    assign ras_empty = (cnt_reg == '0);
    assign ras_full  = (cnt_reg == CW'(RAS_DEPTH));
    assign ras_err   = err_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            ras_mem[sp_reg] <= ret_addr;
        end
    end

    // sp wraps with the power-of-two depth, so a push when full overwrites the oldest entry.
    always_ff @(posedge clk) begin
        if (reset || write_en) begin
            sp_reg  <= '0;
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            if (do_push) begin
                sp_reg <= sp_reg + AW'(1);
                if (cnt_reg != CW'(RAS_DEPTH)) begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end else if (do_pop) begin
                sp_reg  <= sp_reg - AW'(1);
                cnt_reg <= cnt_reg - CW'(1);
            end
            if (take_seq && ret && (cnt_reg == '0)) begin
                err_reg <= 1'b1;
            end
        end
    end
`else
    logic unused_ras;

    assign do_pop     = 1'b0;
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
    assign ras_full   = 1'b0;
    assign ras_err    = 1'b0;
    assign unused_ras = ^{call, ret, ret_addr};
`endif

    always_comb begin
        pc_next = pc_plus;
        if (br_taken) begin
            pc_next = br_target;
        end else if (jmp_taken) begin
            pc_next = jmp_target;
        end else if (do_pop) begin
            pc_next = ras_top;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_RUN;
            pc_reg    <= RESET_V;
        end else if (write_en) begin
            state_reg <= ST_LOAD;
            pc_reg    <= RESET_V;
        end else begin
            case (state_reg)
                ST_LOAD: begin
                    state_reg <= ST_RUN;
                    pc_reg    <= RESET_V;
                end
                ST_HALT: begin
                    if (resume) begin
                        state_reg <= ST_RUN;
                    end
                end
                default: begin
                    if (clk_en && !stall) begin
                        if (halt_req) begin
                            state_reg <= ST_HALT;
                        end else begin
                            pc_reg <= pc_next;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: queue-based reference model compared every cycle,
// plus directed literal expectations. Works with or without PC_RAS_EN.
module tb_pc_unit;

    localparam int PC_W  = 8;
    localparam int STEP  = 1;
    localparam int RV    = 0;
    localparam int DEPTH = 4;
`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic            clk_en;
    logic            stall;
    logic            write_en;
    logic            halt_req;
    logic            resume;
    logic            br_taken;
    logic [PC_W-1:0] br_target;
    logic            jmp_taken;
    logic [PC_W-1:0] jmp_target;
    logic            call;
    logic [PC_W-1:0] ret_addr;
    logic            ret;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus;
    logic [1:0]      state;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_err;

    pc_unit #(.PC_W(PC_W), .STEP(STEP), .RESET_VEC(RV), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .stall(stall), .write_en(write_en),
        .halt_req(halt_req), .resume(resume), .br_taken(br_taken), .br_target(br_target),
        .jmp_taken(jmp_taken), .jmp_target(jmp_target), .call(call), .ret_addr(ret_addr),
        .ret(ret), .pc(pc), .pc_plus(pc_plus), .state(state), .ras_empty(ras_empty),
        .ras_full(ras_full), .ras_err(ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks_total = 0;
    int checks_pass  = 0;
    bit chk_en       = 1'b0;

    // Reference model: PC as an integer, state as 0/1/2, RAS as a bounded queue.
    int m_pc    = 0;
    int m_state = 0;
    int m_ras[$];
    bit m_err   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks_total++;
        if (act == exp) checks_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic model_update();
        if (reset) begin
            m_pc = RV; m_state = 0; m_ras.delete(); m_err = 1'b0;
        end else if (write_en) begin
            m_pc = RV; m_state = 2; m_ras.delete(); m_err = 1'b0;
        end else if (m_state == 2) begin
            m_state = 0;
        end else if (m_state == 1) begin
            if (resume) m_state = 0;
        end else if (clk_en && !stall) begin
            if (halt_req) m_state = 1;
            else if (br_taken) m_pc = br_target;
            else if (jmp_taken) begin
                m_pc = jmp_target;
                if (call && RAS_ON) begin
                    m_ras.push_back(int'(ret_addr));
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                end
            end else if (ret && RAS_ON && m_ras.size() > 0) begin
                m_pc = m_ras.pop_back();
            end else begin
                m_pc = (m_pc + STEP) % (1 << PC_W);
                if (ret && RAS_ON) m_err = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("pc", int'(pc), m_pc);
            chk("pc_plus", int'(pc_plus), (m_pc + STEP) % (1 << PC_W));
            chk("state", int'(state), m_state);
            chk("ras_empty", int'(ras_empty), int'(m_ras.size() == 0));
            chk("ras_full", int'(ras_full), int'(m_ras.size() == DEPTH));
            chk("ras_err", int'(ras_err), int'(m_err));
        end
    end

    task automatic tick();
        model_update();
        @(posedge clk);
        #3;
        $display("t=%0t pc=%02h pc_plus=%02h state=%0d empty=%0b full=%0b err=%0b",
                 $time, pc, pc_plus, state, ras_empty, ras_full, ras_err);
    endtask

    task automatic idle();
        reset = 0; clk_en = 0; stall = 0; write_en = 0; halt_req = 0; resume = 0;
        br_taken = 0; br_target = '0; jmp_taken = 0; jmp_target = '0;
        call = 0; ret_addr = '0; ret = 0;
    endtask

    initial begin
        logic [7:0] hold_pc;
        idle();
        reset  = 1;
        chk_en = 1'b1;
        tick(); tick();
        reset = 0;
        chk("rst_pc", int'(pc), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_empty", int'(ras_empty), 1);

        // Sequential advance 0 -> 4
        clk_en = 1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("seq_pc", int'(pc), i);
        end

        // Wrap at 0xFF
        jmp_taken = 1; jmp_target = 8'hFF;
        tick();
        jmp_taken = 0;
        tick();
        chk("wrap_pc", int'(pc), 8'h00);
        chk("wrap_pc_plus", int'(pc_plus), 8'h01);

        // Branch beats jump; no push from the squashed JAL
        br_taken = 1; br_target = 8'h40; jmp_taken = 1; jmp_target = 8'h80;
        call = 1; ret_addr = 8'h77;
        tick();
        idle(); clk_en = 1;
        chk("br_prio_pc", int'(pc), 8'h40);
        chk("br_prio_empty", int'(ras_empty), 1);

        // Call then return; ret while clk_en=0 is not consumed
        jmp_taken = 1; jmp_target = 8'h20; call = 1; ret_addr = 8'h05;
        tick();
        idle(); clk_en = 1;
        chk("call_pc", int'(pc), 8'h20);
        chk("call_empty", int'(ras_empty), RAS_ON ? 0 : 1);
        tick();
        clk_en = 0; ret = 1;
        tick();
        chk("ret_gated_pc", int'(pc), 8'h21);
        clk_en = 1;
        tick();
        ret = 0;
        chk("ret_pc", int'(pc), RAS_ON ? 8'h05 : 8'h22);
        chk("ret_empty", int'(ras_empty), 1);

        // Overflow: 5 calls into 4 entries, then 5 returns
        for (int i = 1; i <= 5; i++) begin
            jmp_taken = 1; jmp_target = 8'(8'h10 + i); call = 1; ret_addr = 8'(i);
            tick();
        end
        idle(); clk_en = 1;
        chk("ovf_full", int'(ras_full), RAS_ON ? 1 : 0);
        ret = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ret_seq_pc", int'(pc), RAS_ON ? ((i < 4) ? 5 - i : 3) : 8'h16 + i);
        end
        ret = 0;
        chk("ret_err", int'(ras_err), RAS_ON ? 1 : 0);
        chk("ret_err_empty", int'(ras_empty), 1);

        // Stall blocks a branch; halt holds pc; resume restarts
        hold_pc = RAS_ON ? 8'h03 : 8'h1A;
        stall = 1; br_taken = 1; br_target = 8'h99;
        tick();
        chk("stall_pc", int'(pc), int'(hold_pc));
        stall = 0; halt_req = 1;
        tick();
        br_taken = 0;
        chk("halt_state", int'(state), 1);
        chk("halt_pc", int'(pc), int'(hold_pc));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_hold_pc", int'(pc), int'(hold_pc));
        end
        halt_req = 0; resume = 1;
        tick();
        resume = 0;
        chk("resume_state", int'(state), 0);
        tick();
        chk("resume_adv_pc", int'(pc), int'(hold_pc) + 1);

        // Memory load from pc=0x33 with a live RAS entry
        jmp_taken = 1; jmp_target = 8'h33; call = 1; ret_addr = 8'h44;
        tick();
        idle(); clk_en = 1;
        chk("pre_load_pc", int'(pc), 8'h33);
        write_en = 1;
        tick();
        chk("load_state", int'(state), 2);
        chk("load_pc", int'(pc), 8'h00);
        chk("load_empty", int'(ras_empty), 1);
        chk("load_err", int'(ras_err), 0);
        tick();
        write_en = 0;
        tick();
        chk("load_exit_state", int'(state), 0);
        chk("load_exit_pc", int'(pc), 8'h00);
        tick();
        chk("post_load_pc", int'(pc), 8'h01);

        // Reset overrides HALT and LOAD
        halt_req = 1;
        tick();
        halt_req = 0;
        chk("halt2_state", int'(state), 1);
        reset = 1;
        tick();
        reset = 0;
        chk("rst_halt_state", int'(state), 0);
        chk("rst_halt_pc", int'(pc), 0);
        write_en = 1;
        tick();
        reset = 1;
        tick();
        idle();
        chk("rst_load_state", int'(state), 0);
        tick();

        chk_en = 1'b0;
        #20;
        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule
